// File: rtl/lfsr_arb_pkg.sv
// lfsr_arb_pkg: shared FSM state type and LFSR constants for the LFSR arbiter
// Contents: state_t (IDLE, GRANT, SEED), LFSR_W word width, TAP_HI/TAP_LO
// feedback taps, LOCKUP pattern of the XNOR LFSR.
package lfsr_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, SEED} state_t;
    localparam int LFSR_W = 10;
    localparam int TAP_HI = 9;
    localparam int TAP_LO = 6;
    localparam logic [LFSR_W-1:0] LOCKUP = 10'h3FF;
endpackage

// File: rtl/lfsr10_core.sv
// lfsr10_core: XNOR LFSR with step enable, synchronous load, async reset
// Ports: i_clk clock, i_reset async active-high reset (clears to 0),
// i_step advance one state, i_load load i_seed (wins over i_step),
// i_seed load value, o_state current LFSR word.
module lfsr10_core
    import lfsr_arb_pkg::*;
#(
    parameter int W = LFSR_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_step,
    input  logic         i_load,
    input  logic [W-1:0] i_seed,
    output logic [W-1:0] o_state
);
    logic [W-1:0] r_s;
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) r_s <= '0;
        else if (i_load) r_s <= i_seed;
        else if (i_step) r_s <= {r_s[W-2:0], ~(r_s[TAP_HI] ^ r_s[TAP_LO])};
    assign o_state = r_s;
endmodule

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin arbiter handing out LFSR words, one per grant
// Ports: i_clk clock, i_reset async active-high reset, i_req request levels,
// i_seed_load seed strobe, i_seed seed value, i_free_run step LFSR when idle,
// o_gnt registered one-hot grant, o_valid grant present, o_data LFSR word
// delivered with the grant (0 otherwise), o_busy FSM not in IDLE.
module lfsr_arbiter
    import lfsr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_seed_load,
    input  logic [W-1:0]     i_seed,
    input  logic             i_free_run,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_valid,
    output logic [W-1:0]     o_data,
    output logic             o_busy
);
    localparam int PW = $clog2(N_REQ);
    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [W-1:0]     w_lfsr;
    logic [W-1:0]     w_seed;
    logic [PW-1:0]    w_idx;
    logic [PW-1:0]    w_cand;
    logic             w_load;
    logic             w_grant;
    logic             w_step;
    // SEED always lasts one cycle, so a strobe seen while in SEED is ignored
    assign w_load  = i_seed_load && r_state != SEED;
    assign w_grant = |i_req && !w_load;
    assign w_step  = w_grant || (i_free_run && !w_load);
    // all-ones is the XNOR lock-up state; substitute zero
    assign w_seed  = (i_seed == W'(LOCKUP)) ? '0 : i_seed;
    // scan offsets high to low so the nearest active requester at/after ptr wins
    always_comb begin
        w_idx  = '0;
        w_cand = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = PW'((int'(r_ptr) + i) % N_REQ);
            if (i_req[w_cand]) w_idx = w_cand;
        end
    end
    lfsr10_core #(.W(W)) u_core (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_step  (w_step),
        .i_load  (w_load),
        .i_seed  (w_seed),
        .o_state (w_lfsr)
    );
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_load ? SEED : w_grant ? GRANT : IDLE;
            r_gnt   <= w_grant ? (N_REQ'(1) << w_idx) : '0;
            r_valid <= w_grant;
            r_data  <= w_grant ? w_lfsr : '0;
            if (w_grant) r_ptr <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    assign o_gnt   = r_gnt;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_busy  = (r_state != IDLE);
endmodule

// File: tb/tb_lfsr_arbiter.sv
// tb_lfsr_arbiter: directed self-checking bench for lfsr_arbiter
module tb_lfsr_arbiter;
    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [3:0] i_req = '0;
    logic       i_seed_load = 1'b0;
    logic [9:0] i_seed = '0;
    logic       i_free_run = 1'b0;
    logic [3:0] o_gnt;
    logic       o_valid;
    logic [9:0] o_data;
    logic       o_busy;
    int total = 0;
    int bad = 0;

    lfsr_arbiter #(.N_REQ(4), .W(10)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_seed_load (i_seed_load),
        .i_seed      (i_seed),
        .i_free_run  (i_free_run),
        .o_gnt       (o_gnt),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_req = '0;
        i_seed_load = 1'b0;
        i_free_run = 1'b0;
        i_reset = 1'b1;
        #3;
        i_reset = 1'b0;
        tick();
    endtask

    logic [9:0] exp_d1 [4] = '{10'h000, 10'h001, 10'h003, 10'h007};
    logic [3:0] exp_g2 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [9:0] exp_d2 [5] = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F};
    logic [3:0] exp_rr [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        i_reset = 1'b1;
        #2;
        chk("rst_gnt", o_gnt, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", o_busy, 0);
        #1 i_reset = 1'b0;
        tick();

        do_reset();
        i_req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("single_gnt", o_gnt, 4'b0001);
            chk("single_valid", o_valid, 1);
            chk("single_busy", o_busy, 1);
            chk("single_data", o_data, exp_d1[i]);
        end
        i_req = '0;
        tick();
        chk("idle_gnt", o_gnt, 0);
        chk("idle_valid", o_valid, 0);
        chk("idle_data", o_data, 0);
        chk("idle_busy", o_busy, 0);

        do_reset();
        i_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_all_gnt", o_gnt, exp_g2[i]);
            chk("rr_all_data", o_data, exp_d2[i]);
        end

        do_reset();
        i_free_run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("free_valid", o_valid, 0);
        end
        i_free_run = 1'b0;
        i_req = 4'b0100;
        tick();
        chk("free_gnt", o_gnt, 4'b0100);
        chk("free_data", o_data, 10'h0FE);

        do_reset();
        i_req = 4'b0010;
        i_seed = 10'h3FF;
        i_seed_load = 1'b1;
        tick();
        i_seed_load = 1'b0;
        chk("seed_gnt", o_gnt, 0);
        chk("seed_valid", o_valid, 0);
        chk("seed_busy", o_busy, 1);
        tick();
        chk("lock_gnt", o_gnt, 4'b0010);
        chk("lock_data", o_data, 10'h000);

        do_reset();
        i_seed = 10'h155;
        i_seed_load = 1'b1;
        tick();
        i_seed_load = 1'b0;
        i_req = 4'b0001;
        tick();
        chk("s155_gnt", o_gnt, 4'b0001);
        chk("s155_data", o_data, 10'h155);
        tick();
        chk("s2aa_data", o_data, 10'h2AA);

        do_reset();
        i_req = 4'b1111;
        tick();
        tick();
        chk("pre_rst_gnt", o_gnt, 4'b0010);
        #2 i_reset = 1'b1;
        #1;
        chk("async_gnt", o_gnt, 0);
        chk("async_valid", o_valid, 0);
        chk("async_busy", o_busy, 0);
        chk("async_data", o_data, 0);
        #2 i_reset = 1'b0;
        tick();
        chk("post_rst_gnt", o_gnt, 4'b0001);
        chk("post_rst_data", o_data, 10'h000);

        do_reset();
        i_req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) i_req = 4'b0011;
            tick();
            chk("rr_skip_gnt", o_gnt, exp_rr[i]);
        end
        i_req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lfsr_arbiter.md
LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the random source (2..8).
REQ-002 Parameter W, default 10, random word width; taps fixed for W=10.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 req  input  N_REQ  per-requester request level; held until matching gnt bit seen.
REQ-006 seed_load  input  1  single-cycle strobe to load seed into the LFSR.
REQ-007 seed  input  W  seed value, sampled when seed_load=1.
REQ-008 free_run  input  1  when 1, LFSR advances on idle cycles.
REQ-009 gnt  output  N_REQ  registered one-hot grant, one-cycle pulse per grant.
REQ-010 valid  output  1  registered; high exactly when gnt is non-zero.
REQ-011 data  output  W  registered random word delivered with gnt; 0 when valid=0.
REQ-012 busy  output  1  high whenever FSM state is not IDLE.

Function
REQ-013 LFSR step: fb = NOT(s[9] XOR s[6]); next = {s[8:0], fb}.
REQ-014 FSM states: IDLE, GRANT, SEED.
REQ-015 IDLE -> SEED when seed_load=1; else IDLE -> GRANT when any req bit high; else stay IDLE.
REQ-016 GRANT -> SEED when seed_load=1; else stay GRANT if any req bit high; else -> IDLE.
REQ-017 SEED -> GRANT if any req bit high, else -> IDLE; SEED lasts exactly one cycle.
REQ-018 seed_load has priority over any pending grant; no gnt issued in the cycle the FSM is in SEED.
REQ-019 Latency: req sampled at posedge t yields gnt/valid/data at t+1 (registered outputs); back-to-back grants allowed every cycle.
REQ-020 Grant selection: round-robin, searching upward from pointer ptr (wrapping N_REQ-1 -> 0); lowest index at or after ptr wins.
REQ-021 On each grant to index k, ptr <= (k+1) mod N_REQ; ptr unchanged otherwise.
REQ-022 data on a grant equals LFSR value before stepping; LFSR steps in the same cycle, so consecutive grants receive consecutive LFSR states.
REQ-023 With no grant and no seed load, LFSR steps iff free_run=1; otherwise holds.
REQ-024 Seed load sets LFSR <= seed, except seed = all-ones (10'h3FF, XNOR lock-up) loads 10'h000.
REQ-025 A requester dropping req before being granted is skipped; no gnt is issued to a low req bit.
REQ-026 Requester holding req continuously is re-granted only after every other active requester is served once.

Reset
REQ-027 reset=1 forces immediately, independent of clk: state=IDLE, LFSR=10'h000, ptr=0, gnt=0, valid=0, data=0, busy=0.
REQ-028 Reset asserted mid-GRANT drops gnt/valid the same instant; no grant survives reset.
REQ-029 First grant after reset release delivers data=10'h000.

Structure
REQ-030 Package lfsr_arb_pkg holds state enum (IDLE, GRANT, SEED), LFSR_W=10, TAP_HI=9, TAP_LO=6, LOCKUP=10'h3FF.
REQ-031 One sub-module lfsr10_core: W-bit XNOR LFSR with step enable, synchronous load, async active-high reset; arbiter/FSM in lfsr_arbiter.

Verification
REQ-032 Reset, req=0001 held 4 cycles, free_run=0 -> gnt=0001 each cycle from t+1, data 0x000, 0x001, 0x003, 0x007.
REQ-033 Reset, req=1111 held -> gnt 0001, 0010, 0100, 1000, 0001 on consecutive cycles; data 0x000, 0x001, 0x003, 0x007, 0x00F.
REQ-034 Free-run 8 idle cycles from reset then req=0100 -> data=0x0FE (7th step 0x07F, 8th fb=0).
REQ-035 seed_load with seed=0x3FF while req=0010 pending -> one SEED cycle with gnt=0, next grant 0010 with data=0x000.
REQ-036 seed_load seed=0x155 then req=0001 -> data=0x155, next grant data=0x2AA.
REQ-037 Assert reset asynchronously mid-GRANT with req=1111 -> gnt, valid, busy drop before next edge; after release first grant is 0001 with data=0x000.
